inst_prefetch_queue: RTL and testbench

Instruction prefetch queue between the instruction memory port and the `if_id` register. It owns the fetch PC and issues one word-aligned fetch at a time over a ready/valid memory handshake. Returned words are buffered in a small in-order FIFO and presented to `if_id` with their addresses. On a taken jump or branch it discards all buffered and in-flight instructions and redirects fetch.

---
 rtl/inst_prefetch_queue.sv | 147 ++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between the instruction memory port and if_id.
// Owns the fetch PC, issues one word-aligned fetch at a time, buffers returned
// words with their addresses in an in-order FIFO and flushes on redirects.
// Optional feature macro: PREFETCH_BYPASS_EN. When it is defined, a response
// that arrives while the FIFO is empty drives the outputs in the same cycle.
module inst_prefetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [5:0]            stall_in,
  input  logic                  jump_flush_in,
  input  logic [ADDR_WIDTH-1:0] jump_address_in,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic                  mem_ready_in,
  input  logic                  mem_rvalid_in,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic                  inst_valid_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] RESET_ALIGNED = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] WAIT_RESP    = 2'd1;
  localparam logic [1:0] WAIT_DISCARD = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

  logic fifo_empty;
  logic req_accept;
  logic resp_fire;
  logic pop_fifo;
  logic push_fifo;
  logic bypass_taken;
  logic unused_bits;

  // Only stall bit 1 and the word part of the jump target matter here.
  assign unused_bits = ^{stall_in[5:2], stall_in[0], jump_address_in[1:0]};

  assign fifo_empty = (count == '0);
  assign req_accept = mem_req_out && mem_ready_in;
  assign resp_fire  = (state == WAIT_RESP) && mem_rvalid_in;
  assign pop_fifo   = !fifo_empty && !stall_in[1];

  assign mem_req_out  = !reset_in && (state == IDLE) && (count < DEPTH_CNT) && !jump_flush_in;
  assign mem_addr_out = reset_in ? RESET_ALIGNED : fetch_pc;

`ifdef PREFETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit   = fifo_empty && resp_fire && !jump_flush_in && !reset_in;
  assign bypass_taken = bypass_hit && !stall_in[1];
`else
  assign bypass_taken = 1'b0;
`endif

  assign push_fifo = resp_fire && !bypass_taken;

  // Present the FIFO head (or the bypassed response) with its address; NOP when empty.
  always_comb begin
    inst_out       = NOP;
    address_out    = '0;
    inst_valid_out = 1'b0;
    if (!fifo_empty) begin
      inst_out       = inst_mem[rd_ptr];
      address_out    = addr_mem[rd_ptr];
      inst_valid_out = 1'b1;
    end
`ifdef PREFETCH_BYPASS_EN
    else if (bypass_hit) begin
      inst_out       = mem_rdata_in;
      address_out    = req_addr;
      inst_valid_out = 1'b1;
    end
`endif
  end

  // Fetch FSM and PC: one outstanding request, redirect drops any in-flight word.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state    <= IDLE;
      fetch_pc <= RESET_ALIGNED;
      req_addr <= RESET_ALIGNED;
    end else if (jump_flush_in) begin
      fetch_pc <= {jump_address_in[ADDR_WIDTH-1:2], 2'b00};
      state    <= ((state != IDLE) && !mem_rvalid_in) ? WAIT_DISCARD : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_accept) begin
            req_addr <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            state    <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_rvalid_in) state <= IDLE;
        end
        WAIT_DISCARD: begin
          if (mem_rvalid_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; a flush empties the queue and ignores any pop.
  always_ff @(posedge clk_in) begin
    if (reset_in || jump_flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fifo) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fifo)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_fifo, pop_fifo})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: the returned word paired with the address it was fetched from.
  always_ff @(posedge clk_in) begin
    if (!reset_in && !jump_flush_in && push_fifo) begin
      inst_mem[wr_ptr] <= mem_rdata_in;
      addr_mem[wr_ptr] <= req_addr;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue (DEPTH=4, RESET_PC=0x100).
// Memory handshake is driven directly per cycle from directed vectors whose
// expected outputs were worked out by hand; expectations that differ when
// PREFETCH_BYPASS_EN is defined are selected by the BYP constant.
module tb_inst_prefetch_queue;

`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [5:0]  ST  = 6'b000010;
  localparam logic [5:0]  NS  = 6'b111101;

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] jaddr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_aout;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [5:0]  stall_in;
  logic        jump_flush_in;
  logic [31:0] jump_address_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ready_in;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic [31:0] inst_out;
  logic [31:0] address_out;
  logic        inst_valid_out;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;
  vec_t vecs[$];

  inst_prefetch_queue #(
    .DEPTH(4),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .stall_in(stall_in),
    .jump_flush_in(jump_flush_in),
    .jump_address_in(jump_address_in),
    .mem_req_out(mem_req_out),
    .mem_addr_out(mem_addr_out),
    .mem_ready_in(mem_ready_in),
    .mem_rvalid_in(mem_rvalid_in),
    .mem_rdata_in(mem_rdata_in),
    .inst_out(inst_out),
    .address_out(address_out),
    .inst_valid_out(inst_valid_out)
  );

  always #5 clk_in = ~clk_in;

  // Memory word returned for a given fetch address.
  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  // Build a vector; bp marks a response arriving at an empty queue, which the
  // bypass build shows immediately (word rdata at address ba).
  function automatic vec_t mk(input logic r, input logic [5:0] st, input logic fl,
                              input logic [31:0] ja, input logic rd, input logic rv,
                              input logic [31:0] d, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei, input logic [31:0] eo,
                              input logic bp, input logic [31:0] ba);
    vec_t v;
    v.rst = r; v.stall = st; v.flush = fl; v.jaddr = ja;
    v.ready = rd; v.rvalid = rv; v.rdata = d;
    v.e_req = er; v.e_addr = ea;
    if (bp && BYP) begin
      v.e_valid = 1'b1; v.e_inst = d; v.e_aout = ba;
    end else begin
      v.e_valid = ev; v.e_inst = ei; v.e_aout = eo;
    end
    return v;
  endfunction

  task automatic check_field(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s step=%0d got=%h expected=%h", name, step_no, got, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk_in);
    step_no++;
    reset_in        = v.rst;
    stall_in        = v.stall;
    jump_flush_in   = v.flush;
    jump_address_in = v.jaddr;
    mem_ready_in    = v.ready;
    mem_rvalid_in   = v.rvalid;
    mem_rdata_in    = v.rdata;
  endtask

  task automatic check_output(input vec_t v);
    #1;
    check_field("mem_req",    {31'b0, mem_req_out},    {31'b0, v.e_req});
    check_field("mem_addr",   mem_addr_out,            v.e_addr);
    check_field("inst_valid", {31'b0, inst_valid_out}, {31'b0, v.e_valid});
    check_field("inst",       inst_out,                v.e_inst);
    check_field("address",    address_out,             v.e_aout);
  endtask

  task automatic step(input vec_t v);
    apply_stimulus(v);
    check_output(v);
  endtask

  initial begin
    reset_in = 1'b1; stall_in = '0; jump_flush_in = 1'b0; jump_address_in = '0;
    mem_ready_in = 1'b0; mem_rvalid_in = 1'b0; mem_rdata_in = '0;
    @(negedge clk_in);
    @(negedge clk_in);

    // Reset, 1-cycle memory fill, stall until full, drain, ready held low.
    //               r  stall fl jaddr rd rv rdata        req addr         v  inst       aout       bp baddr
    vecs.push_back(mk(1, '0, 0, '0, 1, 0, '0,          0, 32'h100,    0, NOP,       '0,        0, '0));
    vecs.push_back(mk(0, '0, 0, '0, 1, 0, '0,          1, 32'h100,    0, NOP,       '0,        0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 1, w(32'h100),  0, 32'h104,    0, NOP,       '0,        1, 32'h100));
    vecs.push_back(mk(0, '0, 0, '0, 1, 0, '0,          1, 32'h104,    1, w(32'h100), 32'h100,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 1, w(32'h104),  0, 32'h108,    0, NOP,       '0,        1, 32'h104));
    vecs.push_back(mk(0, '0, 0, '0, 1, 0, '0,          1, 32'h108,    1, w(32'h104), 32'h104,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 1, w(32'h108),  0, 32'h10C,    0, NOP,       '0,        1, 32'h108));
    vecs.push_back(mk(0, ST, 0, '0, 1, 0, '0,          1, 32'h10C,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 1, w(32'h10C),  0, 32'h110,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 0, '0,          1, 32'h110,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 1, w(32'h110),  0, 32'h114,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 0, '0,          1, 32'h114,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 1, w(32'h114),  0, 32'h118,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 0, '0,          0, 32'h118,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 0, '0,          0, 32'h118,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, ST, 0, '0, 1, 0, '0,          0, 32'h118,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, NS, 0, '0, 1, 0, '0,          0, 32'h118,    1, w(32'h108), 32'h108,  0, '0));
    vecs.push_back(mk(0, NS, 0, '0, 1, 0, '0,          1, 32'h118,    1, w(32'h10C), 32'h10C,  0, '0));
    vecs.push_back(mk(0, NS, 0, '0, 1, 1, w(32'h118),  0, 32'h11C,    1, w(32'h110), 32'h110,  0, '0));
    vecs.push_back(mk(0, NS, 0, '0, 1, 0, '0,          1, 32'h11C,    1, w(32'h114), 32'h114,  0, '0));
    vecs.push_back(mk(0, NS, 0, '0, 1, 1, w(32'h11C),  0, 32'h120,    1, w(32'h118), 32'h118,  0, '0));
    vecs.push_back(mk(0, '0, 0, '0, 0, 0, '0,          1, 32'h120,    1, w(32'h11C), 32'h11C,  0, '0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, '0, 0, '0, 0, 0, '0,        1, 32'h120,    0, NOP,       '0,        0, '0));
    vecs.push_back(mk(0, '0, 0, '0, 1, 0, '0,          1, 32'h120,    0, NOP,       '0,        0, '0));

    foreach (vecs[i]) step(vecs[i]);

    // Flush to 0x203 while waiting on a 3-cycle response: old word dropped.
    step(mk(0, '0, 1, 32'h203, 1, 0, '0,         0, 32'h124, 0, NOP, '0, 0, '0));
    step(mk(0, '0, 0, '0,      1, 0, '0,         0, 32'h200, 0, NOP, '0, 0, '0));
    step(mk(0, '0, 0, '0,      1, 1, w(32'h120), 0, 32'h200, 0, NOP, '0, 0, '0));
    step(mk(0, '0, 0, '0,      1, 0, '0,         1, 32'h200, 0, NOP, '0, 0, '0));
    step(mk(0, '0, 0, '0,      1, 0, '0,         0, 32'h204, 0, NOP, '0, 0, '0));
    step(mk(0, ST, 0, '0,      1, 1, w(32'h200), 0, 32'h204, 0, NOP, '0, 1, 32'h200));
    step(mk(0, '0, 0, '0,      0, 0, '0,         1, 32'h204, 1, w(32'h200), 32'h200, 0, '0));

    // Flush coinciding with a response: word not enqueued, FSM back to IDLE.
    step(mk(0, '0, 0, '0,      1, 0, '0,         1, 32'h204, 0, NOP, '0, 0, '0));
    step(mk(0, '0, 1, 32'h10,  1, 1, w(32'h204), 0, 32'h208, 0, NOP, '0, 0, '0));
    step(mk(0, '0, 0, '0,      0, 0, '0,         1, 32'h010, 0, NOP, '0, 0, '0));
    step(mk(0, '0, 0, '0,      1, 0, '0,         1, 32'h010, 0, NOP, '0, 0, '0));

    // Response 0x00500093 at 0x10 into an empty queue, not stalled.
    step(mk(0, '0, 0, '0, 1, 1, 32'h0050_0093, 0, 32'h014,
            0, NOP, '0, 1, 32'h010));
    step(mk(0, '0, 0, '0, 0, 0, '0, 1, 32'h014,
            !BYP, BYP ? NOP : 32'h0050_0093, BYP ? 32'h0 : 32'h010, 0, '0));

    // Reset with a request in flight: late response ignored, no discard state.
    step(mk(0, '0, 0, '0, 1, 0, '0,            1, 32'h014, 0, NOP, '0, 0, '0));
    step(mk(1, '0, 0, '0, 1, 0, '0,            0, 32'h100, 0, NOP, '0, 0, '0));
    step(mk(0, '0, 0, '0, 0, 1, 32'hDEAD_BEEF, 1, 32'h100, 0, NOP, '0, 0, '0));
    step(mk(0, '0, 0, '0, 0, 0, '0,            1, 32'h100, 0, NOP, '0, 0, '0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
